// File: rtl/ollar_bus_pkg.sv
// Shared types and helpers for the OLLAR shared-bus arbiter.
package ollar_bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Wide enough for any practical bus; users slice the low DATA_W bits.
  localparam logic [1023:0] ERR_DATA = '1;

  function automatic int clog2(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ollar_rr_pick.sv
// Combinational round-robin priority encoder: first set req at or after pointer.
module ollar_rr_pick import ollar_bus_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     pointer,
  output logic [IDX_W-1:0]     index,
  output logic                 valid
);

  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    index = '0;
    valid = 1'b0;
    j     = 0;
    jj    = '0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = int'(pointer) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      jj = j[IDX_W-1:0];
      if (req[jj]) begin
        index = jj;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ollar_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_CORES cores,
// with per-core bus lock and a saturating mem_ack timeout.
module ollar_bus_arbiter import ollar_bus_pkg::*; #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                        CLOCK_PIN,
  input  logic                        RESET_PIN,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_lock,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic                        core_err,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack
);

  localparam int IDX_W = (NUM_CORES > 1) ? clog2(NUM_CORES) : 1;
  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t state, state_nxt;

  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;
  logic [IDX_W-1:0] ptr, grant, lock_own, pick_idx, sel;
  logic             lock_vld, pick_vld, lock_hit, start, expired;
  logic [CNT_W-1:0] cnt;

  assign addr_v  = core_addr;
  assign wdata_v = core_wdata;

  ollar_rr_pick #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_pick (
    .req     (core_req),
    .pointer (ptr),
    .index   (pick_idx),
    .valid   (pick_vld)
  );

  // A locked owner that is still requesting bypasses the rotation.
  assign lock_hit = lock_vld && core_req[lock_own];
  assign sel      = lock_hit ? lock_own : pick_idx;
  assign start    = lock_hit || pick_vld;
  assign expired  = (cnt == CNT_MAX);

  always_ff @(posedge CLOCK_PIN or negedge RESET_PIN) begin
    if (!RESET_PIN) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (mem_ack || expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_PIN or negedge RESET_PIN) begin
    if (!RESET_PIN) begin
      ptr        <= '0;
      grant      <= '0;
      lock_own   <= '0;
      lock_vld   <= 1'b0;
      cnt        <= '0;
      core_rdata <= '0;
      core_ack   <= '0;
      core_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_vld && !(core_lock[lock_own] && core_req[lock_own])) lock_vld <= 1'b0;
          if (start) begin
            grant     <= sel;
            mem_req   <= 1'b1;
            mem_we    <= core_we[sel];
            mem_addr  <= addr_v[sel];
            mem_wdata <= wdata_v[sel];
            cnt       <= '0;
          end
        end
        BUSY: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            mem_req    <= 1'b0;
            core_rdata <= mem_rdata;
            core_ack   <= NUM_CORES'(1) << grant;
            core_err   <= 1'b0;
          end else if (expired) begin
            mem_req    <= 1'b0;
            core_rdata <= ERR_DATA[DATA_W-1:0];
            core_ack   <= NUM_CORES'(1) << grant;
            core_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          core_ack <= '0;
          core_err <= 1'b0;
          if (core_lock[grant]) begin
            lock_own <= grant;
            lock_vld <= 1'b1;
          end else begin
            lock_vld <= 1'b0;
            ptr      <= (grant == IDX_W'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ollar_bus_arbiter.sv
// Directed scenarios plus a randomized run against a queue-free reference model.
module tb_ollar_bus_arbiter;

  localparam int NC = 4;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     core_req, core_we, core_lock, core_ack;
  logic [NC*32-1:0]  core_addr, core_wdata;
  logic [31:0]       core_rdata, mem_addr, mem_wdata, mem_rdata;
  logic              core_err, mem_req, mem_we, mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  ollar_bus_arbiter #(.NUM_CORES(NC), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLOCK_PIN  (clk),
    .RESET_PIN  (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_lock  (core_lock),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ack   (core_ack),
    .core_err   (core_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic set_core(input int i, input bit req, input bit we, input bit lock,
                          input logic [31:0] a, input logic [31:0] d);
    core_req[i]            = req;
    core_we[i]             = we;
    core_lock[i]           = lock;
    core_addr[i*32 +: 32]  = a;
    core_wdata[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    core_req = '0; core_we = '0; core_lock = '0;
    core_addr = '0; core_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Negedges until mem_req is seen high; -1 if it never rises.
  task automatic wait_req(output int cyc);
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin cyc = i; break; end
    end
  endtask

  task automatic pulse_ack(input logic [31:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    core_req = '1; core_we = '1; core_lock = '0; core_addr = '1; core_wdata = '1;
    mem_ack = 1'b1; mem_rdata = '1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_err++; $display("FAIL reset_mem: got %b/%b/%h/%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({core_ack, core_err, core_rdata} !== '0) begin
      n_err++; $display("FAIL reset_core: got %b/%b/%h want all 0", core_ack, core_err, core_rdata);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_hold: mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_single();
    int c;
    do_reset();
    set_core(2, 1, 1, 0, 32'h100, 32'hDEADBEEF);
    wait_req(c);
    n_cmp++;
    if (c !== 0) begin n_err++; $display("FAIL single_latency: got %0d want 0", c); end
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_bus: got we=%b a=%h d=%h want we=1 a=100 d=deadbeef", mem_we, mem_addr, mem_wdata);
    end
    pulse_ack(32'h1234_5678);
    n_cmp++;
    if ({core_ack, core_err, mem_req} !== {4'b0100, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_ack: got ack=%b err=%b req=%b want 0100/0/0", core_ack, core_err, mem_req);
    end
    core_req[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core_ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_width: got %b want 0000", core_ack); end
    // Pointer should now sit at 3, so core 3 beats core 0.
    set_core(0, 1, 0, 0, 32'h1000, 0);
    set_core(3, 1, 0, 0, 32'h1030, 0);
    wait_req(c);
    n_cmp++;
    if (mem_addr !== 32'h1030) begin n_err++; $display("FAIL single_ptr: got %h want 00001030", mem_addr); end
  endtask

  task automatic test_fairness();
    int c, e;
    do_reset();
    for (int i = 0; i < NC; i++) set_core(i, 1, 0, 0, 32'h1000 + i * 16, 0);
    for (int k = 0; k < 5; k++) begin
      e = k % NC;
      wait_req(c);
      n_cmp++;
      if (c !== ((k == 0) ? 0 : 1) || mem_addr !== 32'h1000 + e * 16) begin
        n_err++; $display("FAIL fair_grant%0d: got lat=%0d addr=%h want core %0d", k, c, mem_addr, e);
      end
      pulse_ack(32'hA0 + k);
      n_cmp++;
      if (core_ack !== (4'b1 << e) || core_rdata !== 32'hA0 + k) begin
        n_err++; $display("FAIL fair_ack%0d: got %b/%h want %b/%h", k, core_ack, core_rdata, 4'b1 << e, 32'hA0 + k);
      end
    end
  endtask

  task automatic test_lock();
    int c;
    do_reset();
    set_core(1, 1, 0, 1, 32'h2010, 0);
    wait_req(c);
    n_cmp++;
    if (mem_addr !== 32'h2010) begin n_err++; $display("FAIL lock_first: got %h want 00002010", mem_addr); end
    set_core(0, 1, 0, 0, 32'h2000, 0);
    pulse_ack(32'h1111_0001);
    n_cmp++;
    if (core_ack !== 4'b0010 || core_rdata !== 32'h1111_0001) begin
      n_err++; $display("FAIL lock_ack1: got %b/%h want 0010/11110001", core_ack, core_rdata);
    end
    set_core(1, 1, 0, 1, 32'h2014, 0);
    wait_req(c);
    n_cmp++;
    if (mem_addr !== 32'h2014) begin n_err++; $display("FAIL lock_second: got %h want 00002014", mem_addr); end
    pulse_ack(32'h1111_0002);
    n_cmp++;
    if (core_ack !== 4'b0010) begin n_err++; $display("FAIL lock_ack2: got %b want 0010", core_ack); end
    set_core(1, 0, 0, 0, 32'h2014, 0);
    wait_req(c);
    n_cmp++;
    if (mem_addr !== 32'h2000) begin n_err++; $display("FAIL lock_release: got %h want 00002000", mem_addr); end
  endtask

  task automatic test_timeout();
    int c, hi;
    do_reset();
    set_core(3, 1, 0, 0, 32'h3030, 0);
    wait_req(c);
    set_core(0, 1, 0, 0, 32'h3000, 0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!mem_req) break;
      hi++;
      @(negedge clk);
    end
    n_cmp++;
    if (hi !== TO + 1) begin n_err++; $display("FAIL to_req_len: got %0d want %0d", hi, TO + 1); end
    n_cmp++;
    if ({core_ack, core_err, core_rdata} !== {4'b1000, 1'b1, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL to_resp: got %b/%b/%h want 1000/1/ffffffff", core_ack, core_err, core_rdata);
    end
    core_req[3] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (core_err !== 1'b0 || core_ack !== 4'b0) begin
      n_err++; $display("FAIL to_clear: got err=%b ack=%b want 0/0000", core_err, core_ack);
    end
    wait_req(c);
    n_cmp++;
    if (mem_addr !== 32'h3000) begin n_err++; $display("FAIL to_next: got %h want 00003000", mem_addr); end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    set_core(1, 1, 1, 0, 32'h4010, 32'h5555);
    wait_req(c);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, core_ack, core_err, core_rdata} !== '0) begin
      n_err++; $display("FAIL rstmid_out: got req=%b we=%b a=%h ack=%b want all 0", mem_req, mem_we, mem_addr, core_ack);
    end
    mem_ack = 1'b1;
    set_core(1, 0, 0, 0, 0, 0);
    set_core(2, 1, 0, 0, 32'h4020, 0);
    set_core(3, 1, 0, 0, 32'h4030, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (core_ack !== 4'b0) begin n_err++; $display("FAIL rstmid_noack%0d: got %b want 0000", k, core_ack); end
    end
    mem_ack = 1'b0;
    rst_n = 1'b1;
    wait_req(c);
    n_cmp++;
    if (c !== 0 || mem_addr !== 32'h4020) begin
      n_err++; $display("FAIL rstmid_grant: got lat=%0d addr=%h want 0/00004020", c, mem_addr);
    end
  endtask

  task automatic test_stray_ack();
    int c;
    do_reset();
    set_core(0, 1, 0, 0, 32'h5000, 0);
    wait_req(c);
    pulse_ack(32'h77);
    core_req[0] = 1'b0;
    @(negedge clk);
    pulse_ack(32'h99);
    n_cmp++;
    if ({core_ack, core_err, mem_req} !== '0 || core_rdata !== 32'h77) begin
      n_err++; $display("FAIL stray_ack: got ack=%b err=%b req=%b rd=%h want 0/0/0/77", core_ack, core_err, mem_req, core_rdata);
    end
    // Pointer must still be 1: core 2 wins over core 0.
    set_core(0, 1, 0, 0, 32'h5000, 0);
    set_core(2, 1, 0, 0, 32'h5020, 0);
    wait_req(c);
    n_cmp++;
    if (c !== 0 || mem_addr !== 32'h5020) begin
      n_err++; $display("FAIL stray_state: got lat=%0d addr=%h want 0/00005020", c, mem_addr);
    end
  endtask

  task automatic rand_core(input int i, input bit force_req);
    set_core(i, force_req || ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom, $urandom);
  endtask

  task automatic test_random();
    int ptr, own, e, lat, hi, c;
    logic [31:0] rd, ea;
    do_reset();
    ptr = 0; own = -1;
    for (int i = 0; i < NC; i++) rand_core(i, 1'b0);
    for (int t = 0; t < 60; t++) begin
      if (core_req == '0) rand_core($urandom_range(0, NC - 1), 1'b1);
      e = -1;
      if (own >= 0 && core_req[own]) e = own;
      else for (int k = 0; k < NC; k++) if (e < 0 && core_req[(ptr + k) % NC]) e = (ptr + k) % NC;
      ea  = core_addr[e*32 +: 32];
      lat = $urandom_range(0, TO + 1);
      rd  = $urandom;
      wait_req(c);
      n_cmp++;
      if (c !== 0 || mem_addr !== ea || mem_we !== core_we[e] || mem_wdata !== core_wdata[e*32 +: 32]) begin
        n_err++; $display("FAIL rnd_grant%0d: got lat=%0d a=%h want core %0d a=%h", t, c, mem_addr, e, ea);
      end
      mem_rdata = rd;
      hi = 0;
      for (int k = 0; k < 20; k++) begin
        if (!mem_req) break;
        hi++;
        mem_ack = (lat <= TO) && (hi == lat + 1);
        @(negedge clk);
      end
      mem_ack = 1'b0;
      n_cmp++;
      if (hi !== ((lat <= TO) ? lat + 1 : TO + 1)) begin
        n_err++; $display("FAIL rnd_len%0d: got %0d want %0d", t, hi, (lat <= TO) ? lat + 1 : TO + 1);
      end
      n_cmp++;
      if (core_ack !== (4'b1 << e) || core_err !== (lat > TO) ||
          core_rdata !== ((lat > TO) ? 32'hFFFF_FFFF : rd)) begin
        n_err++; $display("FAIL rnd_resp%0d: got %b/%b/%h want %b/%b lat=%0d", t, core_ack, core_err, core_rdata, 4'b1 << e, lat > TO, lat);
      end
      rand_core(e, 1'b0);
      if (core_lock[e]) own = e;
      else begin own = -1; ptr = (e + 1) % NC; end
      @(negedge clk);
      n_cmp++;
      if (core_ack !== 4'b0) begin n_err++; $display("FAIL rnd_ackpulse%0d: got %b want 0000", t, core_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/ollar_bus_arbiter.md
# ollar_bus_arbiter

Parametrised round-robin arbiter that lets NUM_CORES OLLAR cores share one memory/peripheral port. It sits between the core array and the shared memory/peripheral bus in the OLLAR top level, replacing the fixed four-core point-to-point wiring. It adds request/acknowledge handshakes, fair rotation, per-core bus lock for atomic read-modify-write, and a bus-timeout error response.

## Interface
- NUM_CORES, 4, number of core ports (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (1..65535)

Ports:
- CLOCK_PIN  in  1  system clock; all logic on rising edge
- RESET_PIN  in  1  asynchronous, active-low reset
- core_req  in  NUM_CORES  per-core transaction request
- core_we  in  NUM_CORES  per-core write enable (1 = write)
- core_lock  in  NUM_CORES  per-core bus-lock request
- core_addr  in  NUM_CORES*ADDR_W  flattened addresses; core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened write data
- core_rdata  out  DATA_W  read data, valid while core_ack is set
- core_ack  out  NUM_CORES  one-hot transaction-complete pulse
- core_err  out  1  timeout flag, valid while core_ack is set
- mem_req  out  1  shared-bus request
- mem_we  out  1  shared-bus write enable
- mem_addr  out  ADDR_W  shared-bus address
- mem_wdata  out  DATA_W  shared-bus write data
- mem_rdata  in  DATA_W  shared-bus read data, sampled with mem_ack
- mem_ack  in  1  shared-bus completion, single-cycle pulse

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If the lock owner is set and its core_req is high, it is granted.
  - Otherwise the first requesting core at or after the rotation pointer is granted, searching upward with wrap from NUM_CORES-1 to 0.
  - With no request, the FSM stays in IDLE.
  - On grant: latch the grant index, mem_req<=1, latch mem_we/addr/wdata from the granted core, clear the timeout counter, go to BUSY.
- BUSY:
  - mem outputs are held stable.
  - When mem_ack is seen: mem_req<=0, core_rdata<=mem_rdata, core_ack[grant]<=1, core_err<=0, go to RESP.
  - When the counter reaches TIMEOUT without mem_ack: mem_req<=0, core_rdata<=all ones, core_err<=1, core_ack[grant]<=1, go to RESP.
- RESP (one cycle):
  - Clear core_ack and core_err, then go to IDLE.
  - If core_lock[grant] is high, the lock owner becomes grant and the pointer does not move.
  - Otherwise the lock owner is cleared and the pointer becomes grant+1, wrapping to 0.
- Lock release: the lock owner is cleared in IDLE when the owner has core_lock low, or has core_lock high but core_req low.
- Core protocol: hold req/we/addr/wdata stable until core_ack. Deassert or change req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- A timeout never blocks other cores. A mem_ack arriving in IDLE or RESP is ignored.
- Reset (asynchronous, any state): state=IDLE, pointer=0, lock owner cleared, grant=0, counter=0; all outputs 0 (core_rdata, core_ack, core_err, mem_req, mem_we, mem_addr, mem_wdata). An in-flight transaction is dropped without ack.

## Timing
- All outputs are registered.
- Grant decision in IDLE in cycle t; mem_req high from t+1.
- mem_ack sampled in cycle t+k; core_ack high in t+k+1 for exactly one cycle; next grant decision at t+k+2.
- Minimum transaction: 3 cycles with mem_ack returned one cycle after mem_req.
- Timeout: with no ack, mem_req stays high for TIMEOUT+1 cycles, then drops; core_ack/core_err follow in the next cycle.
- Counter width is clog2(TIMEOUT+1). The counter saturates, never wraps.

## Structure
- Package ollar_bus_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the function clog2;
  - localparam ERR_DATA = all ones.
- One sub-module: ollar_rr_pick. It is a combinational round-robin priority encoder with inputs req[NUM_CORES] and pointer, and outputs index and valid.
- The FSM, lock logic, counter and datapath muxes stay in ollar_bus_arbiter.

## Test plan
- Single request:
  - Stimulus: core 2 writes addr 0x100, data 0xDEADBEEF; memory acks one cycle after mem_req.
  - Required: mem_we=1, mem_addr=0x100; core_ack=4'b0100 for one cycle; core_err=0; pointer becomes 3.
- Fairness:
  - Stimulus: all four cores request continuously, pointer 0.
  - Required: grants in order 0,1,2,3,0; no core granted twice before all others.
- Lock:
  - Stimulus: core 1 holds core_lock with two back-to-back reads while core 0 requests.
  - Required: both core-1 reads complete before core 0 is granted; core 0 is granted after core 1 drops lock.
- Timeout:
  - Stimulus: TIMEOUT=4, memory never acks core 3.
  - Required: mem_req high for 5 cycles; core_ack[3]=1, core_err=1, core_rdata=0xFFFFFFFF; the next requester is granted.
- Reset mid-operation:
  - Stimulus: RESET_PIN low while in BUSY.
  - Required: all outputs 0 immediately; no core_ack issued; after release the first grant goes to the lowest-indexed requester.
- Stray ack:
  - Stimulus: mem_ack pulsed in IDLE.
  - Required: no core_ack, no state change.
